// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared FSM state type and counter-width helper for the SPI ADC capture block.
package adc_spi_pkg;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, QUIET} state_t;

    // Width of a counter that must hold values 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/adc_spi_capture_if.sv
// adc_spi_capture_if: ADC pin / sample-bus bundle for adc_spi_capture.
//   start     level request, frames repeat while high
//   mdi       serial data, ADC k on bit k
//   test_mode pattern select (only with ADC_TEST_PATTERN_EN)
//   sck       serial clock, idles high
//   CS        chip select, active low
//   busy      high from CS_SETUP entry to end of QUIET
//   en        1-cycle strobe, adc_data updated
//   adc_data  channel k in bits [k*DATA_W +: DATA_W]
// master = capture controller, slave = ADC pins + sample consumer.
interface adc_spi_capture_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 12
);
    logic                     start;
    logic [NUM_CH-1:0]        mdi;
`ifdef ADC_TEST_PATTERN_EN
    logic                     test_mode;
`endif
    logic                     sck;
    logic                     CS;
    logic                     busy;
    logic                     en;
    logic [NUM_CH*DATA_W-1:0] adc_data;

`ifdef ADC_TEST_PATTERN_EN
    modport master (input start, mdi, test_mode, output sck, CS, busy, en, adc_data);
    modport slave  (output start, mdi, test_mode, input sck, CS, busy, en, adc_data);
`else
    modport master (input start, mdi, output sck, CS, busy, en, adc_data);
    modport slave  (output start, mdi, input sck, CS, busy, en, adc_data);
`endif
endinterface

// File: rtl/adc_sck_gen.sv
// adc_sck_gen: SCK divider, half-period CLK_DIV clk_100 cycles, running only while run is high.
//   clk_100, reset_n  clock, async active-low reset
//   run               high in SHIFT; low forces sck high and restarts the divider
//   sck               serial clock, low during the first half-period after run rises
//   rise / fall       high in the cycle whose closing clk_100 edge moves sck 0->1 / 1->0
module adc_sck_gen
    import adc_spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk_100,
    input  logic reset_n,
    input  logic run,
    output logic sck,
    output logic rise,
    output logic fall
);
    localparam int DW = cnt_w(CLK_DIV);

    logic [DW-1:0] div;
    logic          ph;
    logic          wrap;

    assign wrap = run && (div == DW'(CLK_DIV - 1));
    assign sck  = !run || ph;
    assign rise = wrap && !ph;
    assign fall = wrap && ph;

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
            ph  <= 1'b0;
        end else if (!run) begin
            div <= '0;
            ph  <= 1'b0;
        end else if (wrap) begin
            div <= '0;
            ph  <= !ph;
        end else begin
            div <= div + 1'b1;
        end
    end
endmodule

// File: rtl/adc_spi_capture.sv
// adc_spi_capture: multi-channel simultaneous-sampling SPI ADC capture controller.
//   clk_100   system clock
//   reset_n   asynchronous active-low reset
//   bus       adc_spi_capture_if.master (start, mdi, sck, CS, busy, en, adc_data)
// Optional ADC_TEST_PATTERN_EN: adds bus.test_mode, replacing each channel's serial
// input with an internal counting pattern (frame_idx + k).
module adc_spi_capture
    import adc_spi_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int FRAME_BITS = 16,
    parameter int DATA_W     = 12,
    parameter int CLK_DIV    = 2,
    parameter int QUIET_CYC  = 4
) (
    input logic               clk_100,
    input logic               reset_n,
    adc_spi_capture_if.master bus
);
    localparam int BW = cnt_w(FRAME_BITS);
    localparam int CW = cnt_w(CLK_DIV > QUIET_CYC ? CLK_DIV : QUIET_CYC);

    state_t                   state, state_nx;
    logic [CW-1:0]            cnt, cnt_nx;
    logic [BW-1:0]            bit_cnt, bit_cnt_nx;
    logic                     sck, rise, fall, frame_done, en_q;
    logic [NUM_CH-1:0]        sdi;
    logic [NUM_CH*DATA_W-1:0] cap, data_q;

    adc_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk_100,
        .reset_n,
        .run(state == SHIFT),
        .sck,
        .rise,
        .fall
    );

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_cnt_nx = bit_cnt;
        case (state)
            IDLE:     if (bus.start) state_nx = CS_SETUP;
            CS_SETUP: if (cnt == CW'(CLK_DIV - 1)) begin
                          state_nx = SHIFT;
                          cnt_nx   = '0;
                      end else cnt_nx = cnt + 1'b1;
            // A bit period ends on the sck fall; the last one hands over to CS_HOLD
            // with sck parked high instead of falling.
            SHIFT:    if (fall) begin
                          if (bit_cnt == BW'(FRAME_BITS - 1)) begin
                              state_nx   = CS_HOLD;
                              bit_cnt_nx = '0;
                          end else bit_cnt_nx = bit_cnt + 1'b1;
                      end
            CS_HOLD:  if (cnt == CW'(CLK_DIV - 1)) begin
                          state_nx = QUIET;
                          cnt_nx   = '0;
                      end else cnt_nx = cnt + 1'b1;
            QUIET:    if (cnt == CW'(QUIET_CYC - 1)) begin
                          state_nx = bus.start ? CS_SETUP : IDLE;
                          cnt_nx   = '0;
                      end else cnt_nx = cnt + 1'b1;
            default:  state_nx = IDLE;
        endcase
    end

    assign frame_done = (state == CS_HOLD) && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            en_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_cnt <= bit_cnt_nx;
            en_q    <= frame_done;
            if (frame_done) data_q <= cap;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [FRAME_BITS-1:0] sr;
        always_ff @(posedge clk_100 or negedge reset_n) begin
            if (!reset_n) sr <= '0;
            else if (rise) sr <= {sr[FRAME_BITS-2:0], sdi[k]};
        end
        assign cap[k*DATA_W +: DATA_W] = sr[DATA_W-1:0];
    end

`ifdef ADC_TEST_PATTERN_EN
    logic              tm;
    logic [DATA_W-1:0] frame_idx;

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            tm        <= 1'b0;
            frame_idx <= '0;
        end else begin
            if (state_nx == CS_SETUP && state != CS_SETUP) tm <= bus.test_mode;
            if (frame_done) frame_idx <= frame_idx + 1'b1;
        end
    end

    // Pattern word is reloaded throughout CS_SETUP and shifted out MSB first on
    // the same edges the real ADC data would be sampled.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_pat
        logic [FRAME_BITS-1:0] pat;
        always_ff @(posedge clk_100 or negedge reset_n) begin
            if (!reset_n) pat <= '0;
            else if (state == CS_SETUP) pat <= FRAME_BITS'(DATA_W'(frame_idx + DATA_W'(k)));
            else if (rise) pat <= pat << 1;
        end
        assign sdi[k] = tm ? pat[FRAME_BITS-1] : bus.mdi[k];
    end
`else
    assign sdi = bus.mdi;
`endif

    assign bus.sck      = sck;
    assign bus.CS       = (state == IDLE) || (state == QUIET);
    assign bus.busy     = state != IDLE;
    assign bus.en       = en_q;
    assign bus.adc_data = data_q;
endmodule

// File: tb/tb_adc_spi_capture.sv
// tb_adc_spi_capture: directed bench for adc_spi_capture (default build, optional ADC_TEST_PATTERN_EN).
module tb_adc_spi_capture;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    adc_spi_capture_if #(.NUM_CH(2), .DATA_W(12)) bus0 ();
    adc_spi_capture_if #(.NUM_CH(2), .DATA_W(12)) bus1 ();

    adc_spi_capture dut0 (.clk_100(clk), .reset_n(reset_n), .bus(bus0));
    adc_spi_capture #(.CLK_DIV(1)) dut1 (.clk_100(clk), .reset_n(reset_n), .bus(bus1));

    // ADC models: load the next word on CS fall, present one bit per sck fall, MSB first.
    logic [15:0] w0a[$], w0b[$], w1a[$], w1b[$];
    logic [15:0] c0a, c0b, c1a, c1b;
    int rp0 = 0, rp1 = 0, ix0 = 15, ix1 = 15;

    always @(negedge bus0.CS) begin
        c0a = rp0 < w0a.size() ? w0a[rp0] : 16'h0;
        c0b = rp0 < w0b.size() ? w0b[rp0] : 16'h0;
        rp0++;
        ix0 = 15;
    end
    always @(negedge bus0.sck) if (!bus0.CS && ix0 >= 0) begin
        bus0.mdi = {c0b[ix0], c0a[ix0]};
        ix0--;
    end
    always @(negedge bus1.CS) begin
        c1a = rp1 < w1a.size() ? w1a[rp1] : 16'h0;
        c1b = rp1 < w1b.size() ? w1b[rp1] : 16'h0;
        rp1++;
        ix1 = 15;
    end
    always @(negedge bus1.sck) if (!bus1.CS && ix1 >= 0) begin
        bus1.mdi = {c1b[ix1], c1a[ix1]};
        ix1--;
    end

    // Monitors sample 1 time unit after each rising clk edge.
    int cyc = 0;
    int lo0, rise0, en0, busy0, hi0, minhi0, lo1, rise1, en1;
    bit seen0;
    logic psck0, psck1;
    logic [23:0] got0[$], got1[$];
    int encyc0[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (clr) begin
            lo0 = 0; rise0 = 0; en0 = 0; busy0 = 0; hi0 = 0; minhi0 = 1000; seen0 = 0;
            got0.delete(); encyc0.delete();
            lo1 = 0; rise1 = 0; en1 = 0;
            got1.delete();
        end else begin
            if (!bus0.CS) lo0++;
            if (bus0.busy) busy0++;
            if (bus0.sck && !psck0) rise0++;
            if (bus0.en) begin
                en0++;
                got0.push_back(bus0.adc_data);
                encyc0.push_back(cyc);
            end
            if (bus0.CS) hi0++;
            else begin
                if (seen0 && hi0 > 0 && hi0 < minhi0) minhi0 = hi0;
                hi0 = 0;
                seen0 = 1;
            end
            if (!bus1.CS) lo1++;
            if (bus1.sck && !psck1) rise1++;
            if (bus1.en) begin
                en1++;
                got1.push_back(bus1.adc_data);
            end
        end
        psck0 = bus0.sck;
        psck1 = bus1.sck;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wait_idle0(input string tag);
        for (int i = 0; i < 400 && bus0.busy; i++) @(negedge clk);
        chk(tag, bus0.busy, 0);
    endtask

    task automatic wait_idle1(input string tag);
        for (int i = 0; i < 400 && bus1.busy; i++) @(negedge clk);
        chk(tag, bus1.busy, 0);
    endtask

    logic [15:0] r0, r1;
    logic [23:0] exp3[10];
    logic [11:0] pa, pb;

    initial begin
        bus0.start = 1'b0;
        bus1.start = 1'b0;
`ifdef ADC_TEST_PATTERN_EN
        bus0.test_mode = 1'b0;
        bus1.test_mode = 1'b0;
`endif
        // 1: reset values
        @(negedge clk);
        chk("rst_cs", bus0.CS, 1);
        chk("rst_sck", bus0.sck, 1);
        chk("rst_en", bus0.en, 0);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_data", bus0.adc_data, 0);
        reset_n = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        // 2: single frame, one-cycle start
        w0a.push_back(16'h0ABC);
        w0b.push_back(16'h0123);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        chk("t2_cs_latency", bus0.CS, 0);
        chk("t2_busy_rise", bus0.busy, 1);
        wait_idle0("t2_idle_timeout");
        repeat (20) @(negedge clk);
        chk("t2_cs_low_cycles", lo0, 68);
        chk("t2_sck_rises", rise0, 16);
        chk("t2_en_count", en0, 1);
        chk("t2_busy_cycles", busy0, 72);
        chk("t2_data", got0.size() > 0 ? got0[0] : 24'hx, 24'h123ABC);
        chk("t2_cs_idle", bus0.CS, 1);

        // 3: start held, 10 random frames
        clear();
        for (int i = 0; i < 10; i++) begin
            r0 = 16'($urandom);
            r1 = 16'($urandom);
            w0a.push_back(r0);
            w0b.push_back(r1);
            exp3[i] = {r1[11:0], r0[11:0]};
        end
        bus0.start = 1'b1;
        for (int i = 0; i < 1000 && en0 < 10; i++) @(negedge clk);
        bus0.start = 1'b0;
        wait_idle0("t3_idle_timeout");
        repeat (20) @(negedge clk);
        chk("t3_en_count", en0, 10);
        for (int i = 0; i < 10; i++) chk($sformatf("t3_data%0d", i), got0.size() > i ? got0[i] : 24'hx, exp3[i]);
        for (int i = 1; i < 10; i++)
            chk($sformatf("t3_period%0d", i), encyc0.size() > i ? encyc0[i] - encyc0[i-1] : 0, 72);
        chk("t3_cs_high_gap", minhi0, 4);

        // 4: start dropped during bit 5
        clear();
        w0a.push_back(16'hF5A5);
        w0b.push_back(16'h8001);
        bus0.start = 1'b1;
        for (int i = 0; i < 200 && rise0 < 5; i++) @(negedge clk);
        bus0.start = 1'b0;
        wait_idle0("t4_idle_timeout");
        repeat (100) @(negedge clk);
        chk("t4_en_count", en0, 1);
        chk("t4_data", got0.size() > 0 ? got0[0] : 24'hx, 24'h0015A5);
        chk("t4_cs_low_cycles", lo0, 68);
        chk("t4_cs_idle", bus0.CS, 1);
        chk("t4_busy_idle", bus0.busy, 0);

        // CLK_DIV=1 instance: single frame
        clear();
        w1a.push_back(16'h0FED);
        w1b.push_back(16'h0800);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        wait_idle1("d1_idle_timeout");
        repeat (10) @(negedge clk);
        chk("d1_cs_low_cycles", lo1, 34);
        chk("d1_sck_rises", rise1, 16);
        chk("d1_en_count", en1, 1);
        chk("d1_data", got1.size() > 0 ? got1[0] : 24'hx, 24'h800FED);

        // 5: async reset during SHIFT bit 7
        clear();
        w0a.push_back(16'h1234);
        w0b.push_back(16'h0FFF);
        bus0.start = 1'b1;
        for (int i = 0; i < 200 && rise0 < 7; i++) @(negedge clk);
        chk("t5_in_shift", bus0.CS, 0);
        #2;
        reset_n = 1'b0;
        bus0.start = 1'b0;
        #1;
        chk("t5_rst_cs", bus0.CS, 1);
        chk("t5_rst_sck", bus0.sck, 1);
        chk("t5_rst_en", bus0.en, 0);
        chk("t5_rst_busy", bus0.busy, 0);
        chk("t5_rst_data", bus0.adc_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        clear();
        w0a.push_back(16'h0456);
        w0b.push_back(16'h0789);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_idle0("t5_idle_timeout");
        repeat (10) @(negedge clk);
        chk("t5_en_count", en0, 1);
        chk("t5_data", got0.size() > 0 ? got0[0] : 24'hx, 24'h789456);

`ifdef ADC_TEST_PATTERN_EN
        // 6: internal test pattern on both instances from a fresh reset
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus0.test_mode = 1'b1;
        bus1.test_mode = 1'b1;
        clear();
        bus0.start = 1'b1;
        bus1.start = 1'b1;
        for (int i = 0; i < 600 && (got0.size() < 3 || got1.size() < 3); i++) @(negedge clk);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        wait_idle0("t6_idle0_timeout");
        wait_idle1("t6_idle1_timeout");
        for (int i = 0; i < 3; i++) begin
            pa = 12'(i);
            pb = 12'(i + 1);
            chk($sformatf("t6_pat0_%0d", i), got0.size() > i ? got0[i] : 24'hx, {pb, pa});
            chk($sformatf("t6_pat1_%0d", i), got1.size() > i ? got1[i] : 24'hx, {pb, pa});
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
